// File: rtl/ps2_key_tracker.sv
// ----------------------------------------------------------------------------
// ps2_key_tracker
//
// Turns the raw PS/2 scan-code stream into held-key state. Break (0xF0) and
// extended (0xE0) prefixes are parsed. Held keys live on a last-pressed-
// priority stack. The newest held key is presented as the current note, and
// one-cycle strobes mark note-on and note-off events.
//
// Ports
//   clk            : system clock
//   rst            : asynchronous, active-high reset
//   code_in        : scan code, qualified by code_valid_in
//   code_valid_in  : single-cycle strobe, one code per cycle
//   key_out        : newest held key, 0x00 when nothing is held
//   key_valid_out  : high while at least one key is held
//   note_on_out    : one-cycle pulse when key_out changes to a nonzero key
//   note_off_out   : one-cycle pulse when the held count drops to zero
//   count_out      : number of held keys
// ----------------------------------------------------------------------------
module ps2_key_tracker #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 code_in,
  input  logic                       code_valid_in,
  output logic [7:0]                 key_out,
  output logic                       key_valid_out,
  output logic                       note_on_out,
  output logic                       note_off_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BREAK,
    S_EXT,
    S_EXT_BREAK
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      stack_q [DEPTH];
  logic [7:0]      stack_d [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      key_q, key_d;
  logic            valid_q, valid_d;
  logic            note_on_q, note_on_d;
  logic            note_off_q, note_off_d;

  logic            make_ev;
  logic            break_ev;
  logic            ignored_code;
  logic [DEPTH-1:0] hit_vec;
  logic            hit_any;
  logic [CW-1:0]   hit_idx;
  logic [CW-1:0]   top_idx;

  // Codes the keyboard emits for self-test / errors / overrun; never keys.
  assign ignored_code = (code_in == 8'h00) || (code_in == 8'hAA) ||
                        (code_in == 8'hFE) || (code_in == 8'hFF);

  // --------------------------------------------------------------------------
  // Prefix parser: only advances on valid codes. Anything after an 0xE0
  // prefix is swallowed so extended keys never touch the stack.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    make_ev  = 1'b0;
    break_ev = 1'b0;
    if (code_valid_in) begin
      case (state_q)
        S_IDLE: begin
          if (code_in == 8'hF0) begin
            state_d = S_BREAK;
          end else if (code_in == 8'hE0) begin
            state_d = S_EXT;
          end else if (!ignored_code) begin
            make_ev = 1'b1;
          end
        end
        S_BREAK: begin
          break_ev = 1'b1;
          state_d  = S_IDLE;
        end
        S_EXT: begin
          state_d = (code_in == 8'hF0) ? S_EXT_BREAK : S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Parallel search: one comparator per slot, masked to the occupied slots.
  // Keys are unique in the stack, so at most one bit is ever set.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign hit_vec[gi] = (CW'(gi) < count_q) && (stack_q[gi] == code_in);
  end

  assign hit_any = |hit_vec;

  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit_vec[i]) begin
        hit_idx = CW'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stack update. Slot 0 is the oldest entry, slot count-1 the newest.
  // Unoccupied slots are kept at zero, which lets a removal simply shift the
  // upper part down by one.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stack_d[i] = stack_q[i];
    end
    count_d = count_q;

    if (make_ev && !hit_any) begin
      if (count_q == CW'(DEPTH)) begin
        // Full: evict the oldest, new key lands on top.
        for (int i = 0; i < DEPTH - 1; i++) begin
          stack_d[i] = stack_q[i+1];
        end
        stack_d[DEPTH-1] = code_in;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == count_q) begin
            stack_d[i] = code_in;
          end
        end
        count_d = count_q + CW'(1);
      end
    end else if (break_ev && hit_any) begin
      // Close the gap left by the released key; press order is preserved.
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (CW'(i) >= hit_idx) begin
          stack_d[i] = stack_q[i+1];
        end
      end
      stack_d[DEPTH-1] = 8'h00;
      count_d = count_q - CW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Output derivation. The presented key is always the new top of stack, so a
  // note-on is simply "top changed to something nonzero": this covers new
  // presses, overflow pushes and the retrigger after popping the top key.
  // Releases below the top leave the top unchanged and therefore stay silent.
  // --------------------------------------------------------------------------
  assign top_idx = count_d - CW'(1);

  always_comb begin
    key_d = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if ((count_d != '0) && (CW'(i) == top_idx)) begin
        key_d = stack_d[i];
      end
    end
    valid_d    = (count_d != '0);
    note_on_d  = (key_d != 8'h00) && (key_d != key_q);
    note_off_d = (count_q != '0) && (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      key_q      <= 8'h00;
      valid_q    <= 1'b0;
      note_on_q  <= 1'b0;
      note_off_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      key_q      <= key_d;
      valid_q    <= valid_d;
      note_on_q  <= note_on_d;
      note_off_q <= note_off_d;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

  assign key_out       = key_q;
  assign key_valid_out = valid_q;
  assign note_on_out   = note_on_q;
  assign note_off_out  = note_off_q;
  assign count_out     = count_q;

endmodule
